// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder state encoding, default address, ACK/NACK bit levels.
package i2c_pkg;
  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
    ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK
  } i2c_state_e;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h68;
  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;
endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with START/STOP and SCL edge detection.
// Define I2C_SLAVE_GLITCH_FILTER_EN to require 3 equal samples before a line changes.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [1:0] scl_ff, sda_ff;
  logic       scl_q, sda_q, scl_d, sda_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_h, sda_h;

  // Current sample plus two history samples must agree before the line moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_h <= 2'b11;
      sda_h <= 2'b11;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_ff[1]};
      sda_h <= {sda_h[0], sda_ff[1]};
      if (scl_h == {2{scl_ff[1]}}) scl_q <= scl_ff[1];
      if (sda_h == {2{sda_ff[1]}}) sda_q <= sda_ff[1];
    end
  end
`else
  assign scl_q = scl_ff[1];
  assign sda_q = sda_ff[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_q;
      sda_d <= sda_q;
    end
  end

  assign sda_s    = sda_q;
  assign scl_rise = scl_q & ~scl_d;
  assign scl_fall = ~scl_q & scl_d;
  assign start    = scl_q & scl_d & sda_d & ~sda_q;
  assign stop     = scl_q & scl_d & ~sda_d & sda_q;
endmodule

// File: rtl/i2c_slave.sv
// I2C register-pointer responder: addr byte, pointer byte, then auto-incrementing data.
// Optional SCL/SDA glitch filter enabled by I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = I2C_DEFAULT_ADDR,
  parameter logic [7:0] RESET_PTR  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  input  logic [7:0] reg_rdata,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       busy
);
  i2c_state_e state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, rx_byte;
  logic       rw, ack_on, sda_oe;
  logic       sda_s, scl_rise, scl_fall, start, stop;

  i2c_line_sync u_sync (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .sda_s(sda_s), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start(start), .stop(stop)
  );

  assign sda     = sda_oe ? 1'b0 : 1'bz;
  assign rx_byte = {shreg[6:0], sda_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd7;
      shreg     <= 8'h00;
      rw        <= 1'b0;
      ack_on    <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= RESET_PTR;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      if (start) begin
        state   <= ST_ADDR;
        bit_cnt <= 3'd7;
        sda_oe  <= 1'b0;
        ack_on  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        ack_on <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_REG, ST_WR_DATA: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              case (state)
                ST_ADDR: if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state <= ST_ADDR_ACK;
                  rw    <= rx_byte[0];
                  busy  <= 1'b1;
                end else begin
                  state <= ST_IDLE;
                end
                ST_REG: begin
                  reg_addr <= rx_byte;
                  state    <= ST_REG_ACK;
                end
                default: begin
                  reg_wdata <= rx_byte;
                  reg_we    <= 1'b1;
                  state     <= ST_WR_ACK;
                end
              endcase
            end
          end
          // First falling edge pulls SDA low, the second one ends the ACK slot.
          ST_ADDR_ACK, ST_REG_ACK, ST_WR_ACK: if (scl_fall) begin
            if (!ack_on) begin
              ack_on <= 1'b1;
              sda_oe <= 1'b1;
            end else begin
              ack_on  <= 1'b0;
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd7;
              if (state == ST_ADDR_ACK && rw) begin
                state  <= ST_RD_DATA;
                shreg  <= reg_rdata;
                sda_oe <= ~reg_rdata[7];
              end else if (state == ST_ADDR_ACK) begin
                state <= ST_REG;
              end else begin
                state <= ST_WR_DATA;
                if (state == ST_WR_ACK) reg_addr <= reg_addr + 8'd1;
              end
            end
          end
          ST_RD_DATA: if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              state  <= ST_RD_ACK;
              sda_oe <= 1'b0;
            end else begin
              shreg   <= {shreg[6:0], 1'b0};
              sda_oe  <= ~shreg[6];
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          // Pointer advances at the ACK sample so reg_rdata is settled by the reload edge.
          ST_RD_ACK: begin
            if (scl_rise) begin
              reg_addr <= reg_addr + 8'd1;
              if (sda_s == I2C_NACK) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                ack_on <= 1'b1;
              end
            end else if (scl_fall && ack_on) begin
              ack_on  <= 1'b0;
              state   <= ST_RD_DATA;
              shreg   <= reg_rdata;
              sda_oe  <= ~reg_rdata[7];
              bit_cnt <= 3'd7;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged master, register-file model, random bursts.
module tb_i2c_slave;
  localparam int Q = 8;

  logic       clk = 1'b0, rst_n = 1'b0, m_scl = 1'b1, m_sda = 1'b1;
  wire        sda;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, busy;
  logic [7:0] mem [256];
  logic [7:0] txb [8];
  logic [7:0] rxb [8];
  logic [15:0] wq[$];
  logic [7:0] ptr;
  int errors = 0, checks = 0;

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);
  assign reg_rdata = mem[reg_addr];

  always #5 clk = ~clk;

  i2c_slave dut (
    .clk(clk), .rst_n(rst_n), .scl(m_scl), .sda(sda),
    .reg_addr(reg_addr), .reg_rdata(reg_rdata), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .busy(busy)
  );

  always @(posedge clk) if (rst_n && reg_we) wq.push_back({reg_addr, reg_wdata});

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wclk(Q); m_scl = 1'b1; wclk(Q);
    m_sda = 1'b0; wclk(Q); m_scl = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wclk(Q); m_scl = 1'b1; wclk(Q); m_sda = 1'b1; wclk(Q);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    m_sda = b; wclk(Q); m_scl = 1'b1;
    if (glitch) begin
      wclk(2); m_scl = 1'b0; wclk(1); m_scl = 1'b1; wclk(Q - 3);
    end else wclk(Q);
    wclk(Q); m_scl = 1'b0; wclk(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; wclk(Q); m_scl = 1'b1; wclk(Q);
    b = sda; wclk(Q); m_scl = 1'b0; wclk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int gbit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == gbit);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    send_bit(nack, 1'b0);
  endtask

  task automatic bus_write(input logic [7:0] p, input int n, output int nacks);
    logic a;
    nacks = 0;
    i2c_start();
    write_byte(8'hD0, -1, a); nacks += int'(a);
    write_byte(p, -1, a);     nacks += int'(a);
    for (int i = 0; i < n; i++) begin
      write_byte(txb[i], -1, a); nacks += int'(a);
    end
    i2c_stop(); wclk(Q);
  endtask

  task automatic bus_read(input logic [7:0] p, input int n, output int nacks);
    logic a;
    nacks = 0;
    i2c_start();
    write_byte(8'hD0, -1, a); nacks += int'(a);
    write_byte(p, -1, a);     nacks += int'(a);
    i2c_start();
    write_byte(8'hD1, -1, a); nacks += int'(a);
    for (int i = 0; i < n; i++) read_byte(rxb[i], i == n - 1);
    i2c_stop(); wclk(Q);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wclk(3);
    checks += 5;
    if (sda !== 1'b1)       begin errors++; $display("FAIL reset_sda: got %b expected 1", sda); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (reg_we !== 1'b0)    begin errors++; $display("FAIL reset_we: got %b expected 0", reg_we); end
    if (reg_addr !== 8'h00) begin errors++; $display("FAIL reset_ptr: got %h expected 00", reg_addr); end
    if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h expected 00", reg_wdata); end
    rst_n = 1'b1; wclk(4);
    ptr = 8'h00;
  endtask

  task automatic test_write();
    int nk;
    wq.delete();
    txb[0] = 8'h00; txb[1] = 8'h01;
    bus_write(8'h6B, 2, nk);
    ptr = 8'h6D;
    checks += 4;
    if (nk != 0) begin errors++; $display("FAIL write_acks: got %0d nacks expected 0", nk); end
    if (wq.size() != 2) begin errors++; $display("FAIL write_count: got %0d expected 2", wq.size()); end
    else begin
      checks += 2;
      if (wq[0] !== 16'h6B00) begin errors++; $display("FAIL write_0: got %h expected 6b00", wq[0]); end
      if (wq[1] !== 16'h6C01) begin errors++; $display("FAIL write_1: got %h expected 6c01", wq[1]); end
    end
    if (reg_addr !== ptr) begin errors++; $display("FAIL write_ptr: got %h expected %h", reg_addr, ptr); end
    if (busy !== 1'b0) begin errors++; $display("FAIL write_busy: got %b expected 0", busy); end
  endtask

  task automatic test_busy();
    logic a;
    i2c_start();
    write_byte(8'hD0, -1, a);
    wclk(2);
    checks += 3;
    if (a !== 1'b0) begin errors++; $display("FAIL busy_ack: got %b expected 0", a); end
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_high: got %b expected 1", busy); end
    i2c_stop(); wclk(Q);
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_stop: got %b expected 0", busy); end
  endtask

  task automatic test_read();
    int nk;
    mem[8'h75] = 8'h68;
    bus_read(8'h75, 1, nk);
    ptr = 8'h76;
    checks += 4;
    if (nk != 0) begin errors++; $display("FAIL read_acks: got %0d expected 0", nk); end
    if (rxb[0] !== 8'h68) begin errors++; $display("FAIL read_data: got %h expected 68", rxb[0]); end
    if (busy !== 1'b0) begin errors++; $display("FAIL read_busy: got %b expected 0", busy); end
    if (reg_addr !== ptr) begin errors++; $display("FAIL read_ptr: got %h expected %h", reg_addr, ptr); end
  endtask

  task automatic test_burst_wrap();
    int nk;
    logic [7:0] p;
    bus_read(8'hFE, 3, nk);
    ptr = 8'h01;
    checks += 2;
    if (nk != 0) begin errors++; $display("FAIL wrap_acks: got %0d expected 0", nk); end
    for (int i = 0; i < 3; i++) begin
      p = 8'hFE + 8'(i);
      checks++;
      if (rxb[i] !== mem[p]) begin errors++; $display("FAIL wrap_byte%0d: got %h expected %h", i, rxb[i], mem[p]); end
    end
    if (reg_addr !== ptr) begin errors++; $display("FAIL wrap_ptr: got %h expected %h", reg_addr, ptr); end
  endtask

  task automatic test_bad_addr();
    logic a, a2;
    wq.delete();
    i2c_start();
    write_byte(8'hA0, -1, a);
    wclk(2);
    checks += 5;
    if (a !== 1'b1) begin errors++; $display("FAIL bad_ack: got %b expected 1", a); end
    if (busy !== 1'b0) begin errors++; $display("FAIL bad_busy: got %b expected 0", busy); end
    write_byte(8'h11, -1, a2);
    write_byte(8'h22, -1, a2);
    i2c_stop(); wclk(Q);
    if (a2 !== 1'b1) begin errors++; $display("FAIL bad_data_ack: got %b expected 1", a2); end
    if (wq.size() != 0) begin errors++; $display("FAIL bad_we: got %0d writes expected 0", wq.size()); end
    if (reg_addr !== ptr) begin errors++; $display("FAIL bad_ptr: got %h expected %h", reg_addr, ptr); end
  endtask

  task automatic test_abort();
    logic a;
    int nk;
    wq.delete();
    i2c_start();
    write_byte(8'hD0, -1, a);
    write_byte(8'h40, -1, a);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    i2c_stop(); wclk(Q);
    ptr = 8'h40;
    checks += 4;
    if (wq.size() != 0) begin errors++; $display("FAIL abort_we: got %0d writes expected 0", wq.size()); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    if (sda !== 1'b1) begin errors++; $display("FAIL abort_sda: got %b expected 1", sda); end
    if (reg_addr !== ptr) begin errors++; $display("FAIL abort_ptr: got %h expected %h", reg_addr, ptr); end
    txb[0] = 8'h5A;
    bus_write(8'h41, 1, nk);
    ptr = 8'h42;
    checks += 3;
    if (nk != 0) begin errors++; $display("FAIL abort_next_acks: got %0d expected 0", nk); end
    if (wq.size() != 1 || wq[0] !== 16'h415A) begin
      errors++; $display("FAIL abort_next_we: got %0d writes first %h expected 1 of 415a", wq.size(), wq.size() ? wq[0] : 16'h0);
    end
    if (reg_addr !== ptr) begin errors++; $display("FAIL abort_next_ptr: got %h expected %h", reg_addr, ptr); end
  endtask

  task automatic test_random();
    int nk, n;
    logic [7:0] p, e;
    for (int it = 0; it < 10; it++) begin
      p = 8'($urandom);
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 0) begin
        wq.delete();
        for (int i = 0; i < n; i++) txb[i] = 8'($urandom);
        bus_write(p, n, nk);
        checks += 2;
        if (nk != 0) begin errors++; $display("FAIL rnd_wr_acks: got %0d expected 0", nk); end
        if (wq.size() != n) begin errors++; $display("FAIL rnd_wr_count: got %0d expected %0d", wq.size(), n); end
        else for (int i = 0; i < n; i++) begin
          e = p + 8'(i);
          checks++;
          if (wq[i] !== {e, txb[i]}) begin errors++; $display("FAIL rnd_wr%0d: got %h expected %h", i, wq[i], {e, txb[i]}); end
        end
      end else begin
        bus_read(p, n, nk);
        checks++;
        if (nk != 0) begin errors++; $display("FAIL rnd_rd_acks: got %0d expected 0", nk); end
        for (int i = 0; i < n; i++) begin
          e = mem[p + 8'(i)];
          checks++;
          if (rxb[i] !== e) begin errors++; $display("FAIL rnd_rd%0d: got %h expected %h", i, rxb[i], e); end
        end
      end
      ptr = p + 8'(n);
      checks++;
      if (reg_addr !== ptr) begin errors++; $display("FAIL rnd_ptr: got %h expected %h", reg_addr, ptr); end
    end
  endtask

  task automatic test_reset_mid();
    logic a;
    int nk;
    mem[ptr] = 8'h3C;
    i2c_start();
    write_byte(8'hD1, -1, a);
    checks += 2;
    if (sda !== 1'b0) begin errors++; $display("FAIL mid_driving: got %b expected 0", sda); end
    rst_n = 1'b0; #1;
    if (sda !== 1'b1) begin errors++; $display("FAIL mid_release: got %b expected 1", sda); end
    wclk(2);
    m_scl = 1'b1; m_sda = 1'b1; wclk(4);
    rst_n = 1'b1; wclk(4);
    ptr = 8'h00;
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    wq.delete();
    txb[0] = 8'hC3;
    bus_write(8'h10, 1, nk);
    ptr = 8'h11;
    if (wq.size() != 1 || wq[0] !== 16'h10C3 || reg_addr !== ptr) begin
      errors++; $display("FAIL mid_after: got %0d writes ptr %h expected 1 write ptr %h", wq.size(), reg_addr, ptr);
    end
  endtask

  task automatic test_glitch();
    logic a;
    logic [7:0] d, exp_d;
    d = 8'hA5;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    exp_d = d;
`else
    exp_d = {d[7:3], d[3], d[2:1]};
`endif
    wq.delete();
    i2c_start();
    write_byte(8'hD0, -1, a);
    write_byte(8'h20, -1, a);
    write_byte(d, 3, a);
    i2c_stop(); wclk(Q);
    ptr = 8'h21;
    checks += 2;
    if (wq.size() != 1 || wq[0] !== {8'h20, exp_d}) begin
      errors++; $display("FAIL glitch_we: got %0d writes first %h expected 1 of %h", wq.size(), wq.size() ? wq[0] : 16'h0, {8'h20, exp_d});
    end
    if (reg_addr !== ptr) begin errors++; $display("FAIL glitch_ptr: got %h expected %h", reg_addr, ptr); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_write();
    test_busy();
    test_read();
    test_burst_wrap();
    test_bad_addr();
    test_abort();
    test_random();
    test_reset_mid();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
